// File: rtl/opamp_comparator.sv
// Schmitt-style comparator: turns a signed chaotic sample into a registered chaos bit
// and keeps a saturating running (#ones - #zeros) balance.
module opamp_comparator #(
    parameter int unsigned             WIDTH     = 16,
    parameter logic signed [WIDTH-1:0] THRESHOLD = '0,
    parameter logic [WIDTH-2:0]        HYST      = '0,
    parameter int unsigned             BAL_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            chaotic_value,
    output logic                        chaos_bit,
    output logic                        bit_valid,
    output logic signed [BAL_WIDTH-1:0] balance
);
    localparam int unsigned EW = WIDTH + 2;
    localparam logic signed [BAL_WIDTH-1:0] BAL_MAX = {1'b0, {(BAL_WIDTH-1){1'b1}}};
    localparam logic signed [BAL_WIDTH-1:0] BAL_MIN = {1'b1, {(BAL_WIDTH-1){1'b0}}};
    localparam logic signed [BAL_WIDTH-1:0] BAL_ONE = {{(BAL_WIDTH-1){1'b0}}, 1'b1};

    logic signed [EW-1:0]        sample_ext;
    logic signed [EW-1:0]        thr_ext;
    logic signed [EW-1:0]        hyst_ext;
    logic signed [EW-1:0]        hi;
    logic signed [EW-1:0]        lo;
    logic                        next_bit;
    logic signed [BAL_WIDTH-1:0] next_bal;

    // Two guard bits keep THRESHOLD +/- HYST from wrapping at the range extremes.
    always_comb begin
        sample_ext = {{2{chaotic_value[WIDTH-1]}}, chaotic_value};
        thr_ext    = {{2{THRESHOLD[WIDTH-1]}}, THRESHOLD};
        hyst_ext   = {3'b000, HYST};
        hi         = thr_ext + hyst_ext;
        lo         = thr_ext - hyst_ext;
    end

    always_comb begin
        next_bit = chaos_bit;
        if (sample_ext > hi) begin
            next_bit = 1'b1;
        end else if (sample_ext <= lo) begin
            next_bit = 1'b0;
        end

        next_bal = balance;
        if (next_bit) begin
            if (balance != BAL_MAX) next_bal = balance + BAL_ONE;
        end else begin
            if (balance != BAL_MIN) next_bal = balance - BAL_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chaos_bit <= 1'b0;
            bit_valid <= 1'b0;
            balance   <= '0;
        end else begin
            bit_valid <= in_valid;
            if (in_valid) begin
                chaos_bit <= next_bit;
                balance   <= next_bal;
            end
        end
    end
endmodule

// File: tb/tb_opamp_comparator.sv
// Scoreboard bench for opamp_comparator: plain, hysteresis and narrow-balance instances.
module tb_opamp_comparator;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] chaotic_value;

    logic        b_bit, b_vld;
    logic signed [15:0] b_bal;
    logic        h_bit, h_vld;
    logic signed [15:0] h_bal;
    logic        s_bit, s_vld;
    logic signed [3:0]  s_bal;

    opamp_comparator u_basic (
        .clk(clk), .rst(rst), .in_valid(in_valid), .chaotic_value(chaotic_value),
        .chaos_bit(b_bit), .bit_valid(b_vld), .balance(b_bal)
    );

    opamp_comparator #(.THRESHOLD(16'sh1000), .HYST(15'h0100)) u_hyst (
        .clk(clk), .rst(rst), .in_valid(in_valid), .chaotic_value(chaotic_value),
        .chaos_bit(h_bit), .bit_valid(h_vld), .balance(h_bal)
    );

    opamp_comparator #(.BAL_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .chaotic_value(chaotic_value),
        .chaos_bit(s_bit), .bit_valid(s_vld), .balance(s_bal)
    );

    typedef struct {
        logic b;
        int   bal;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   dsel  = 0;
    logic cur_bit, cur_vld;
    int   cur_bal;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_bit = b_bit;
        cur_vld = b_vld;
        cur_bal = int'(b_bal);
        if (dsel == 1) begin
            cur_bit = h_bit;
            cur_vld = h_vld;
            cur_bal = int'(h_bal);
        end else if (dsel == 2) begin
            cur_bit = s_bit;
            cur_vld = s_vld;
            cur_bal = int'(s_bal);
        end
    end

    task automatic drive(input logic [15:0] v, input logic vld, input logic eb, input int ebal);
        exp_t e;
        @(negedge clk);
        chaotic_value = v;
        in_valid      = vld;
        if (vld) begin
            e.b   = eb;
            e.bal = ebal;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        chaotic_value = 16'h4000;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({b_bit, b_vld, b_bal} !== 18'h0) begin
            bad++; $display("FAIL reset_basic got bit=%b vld=%b bal=%0d exp 0/0/0", b_bit, b_vld, b_bal);
        end
        total++;
        if ({h_bit, h_vld, h_bal} !== 18'h0) begin
            bad++; $display("FAIL reset_hyst got bit=%b vld=%b bal=%0d exp 0/0/0", h_bit, h_vld, h_bal);
        end
        total++;
        if ({s_bit, s_vld, s_bal} !== 6'h0) begin
            bad++; $display("FAIL reset_sat got bit=%b vld=%b bal=%0d exp 0/0/0", s_bit, s_vld, s_bal);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_sign_and_bounds();
        logic [15:0] vals [9] = '{16'h4000, 16'h2000, 16'h8288, 16'hE667,
                                  16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic        eb   [9] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
        int          ebal [9] = '{1, 2, 1, 0, -1, 0, 1, 0, -1};
        exp_t e;
        dsel = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(vals[i], 1'b1, eb[i], ebal[i]);
            @(posedge clk);
            #1;
            total++;
            if (cur_vld !== 1'b1) begin
                bad++; $display("FAIL sign_valid[%0d] got=%b exp=1", i, cur_vld);
            end
            if (sb.size() == 0) begin
                total++; bad++; $display("FAIL sign_sb_empty[%0d] got=0 exp>=1", i);
            end else begin
                e = sb.pop_front();
                total++;
                if (cur_bit !== e.b) begin
                    bad++; $display("FAIL sign_bit[%0d] val=%h got=%b exp=%b", i, vals[i], cur_bit, e.b);
                end
                total++;
                if (cur_bal !== e.bal) begin
                    bad++; $display("FAIL sign_bal[%0d] got=%0d exp=%0d", i, cur_bal, e.bal);
                end
            end
        end
    endtask

    task automatic test_hysteresis();
        logic [15:0] vals [5] = '{16'h1200, 16'h1000, 16'h0F00, 16'h1050, 16'h1101};
        logic        eb   [5] = '{1, 1, 0, 0, 1};
        int          ebal [5] = '{1, 2, 1, 0, 1};
        exp_t e;
        dsel = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(vals[i], 1'b1, eb[i], ebal[i]);
            @(posedge clk);
            #1;
            total++;
            if (cur_vld !== 1'b1) begin
                bad++; $display("FAIL hyst_valid[%0d] got=%b exp=1", i, cur_vld);
            end
            if (sb.size() == 0) begin
                total++; bad++; $display("FAIL hyst_sb_empty[%0d] got=0 exp>=1", i);
            end else begin
                e = sb.pop_front();
                total++;
                if (cur_bit !== e.b) begin
                    bad++; $display("FAIL hyst_bit[%0d] val=%h got=%b exp=%b", i, vals[i], cur_bit, e.b);
                end
                total++;
                if (cur_bal !== e.bal) begin
                    bad++; $display("FAIL hyst_bal[%0d] got=%0d exp=%0d", i, cur_bal, e.bal);
                end
            end
        end
    endtask

    task automatic test_idle();
        exp_t e;
        dsel = 0;
        do_reset();
        drive(16'h4000, 1'b1, 1'b1, 1);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (cur_vld !== 1'b1 || cur_bit !== e.b || cur_bal !== e.bal) begin
            bad++; $display("FAIL idle_first got vld=%b bit=%b bal=%0d exp 1/%b/%0d", cur_vld, cur_bit, cur_bal, e.b, e.bal);
        end
        for (int i = 0; i < 3; i++) begin
            drive(16'h8288, 1'b0, 1'b0, 0);
            @(posedge clk);
            #1;
            total++;
            if (cur_vld !== 1'b0) begin
                bad++; $display("FAIL idle_valid[%0d] got=%b exp=0", i, cur_vld);
            end
            total++;
            if (cur_bit !== 1'b1) begin
                bad++; $display("FAIL idle_bit[%0d] got=%b exp=1", i, cur_bit);
            end
            total++;
            if (cur_bal !== 1) begin
                bad++; $display("FAIL idle_bal[%0d] got=%0d exp=1", i, cur_bal);
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL idle_sb_left got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        dsel = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(16'h2000 + 16'(i), 1'b1, 1'b1, i + 1);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (cur_bit !== e.b || cur_bal !== e.bal || cur_vld !== 1'b1) begin
                bad++; $display("FAIL mid_stream[%0d] got bit=%b bal=%0d vld=%b exp %b/%0d/1", i, cur_bit, cur_bal, cur_vld, e.b, e.bal);
            end
        end
        chaotic_value = 16'h4000;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (cur_bit !== 1'b0 || cur_vld !== 1'b0 || cur_bal !== 0) begin
            bad++; $display("FAIL mid_async_clear got bit=%b vld=%b bal=%0d exp 0/0/0", cur_bit, cur_vld, cur_bal);
        end
        @(posedge clk);
        #1;
        total++;
        if (cur_bit !== 1'b0 || cur_vld !== 1'b0 || cur_bal !== 0) begin
            bad++; $display("FAIL mid_held got bit=%b vld=%b bal=%0d exp 0/0/0", cur_bit, cur_vld, cur_bal);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        drive(16'h2000, 1'b1, 1'b1, 1);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (cur_bit !== e.b || cur_bal !== e.bal || cur_vld !== 1'b1) begin
            bad++; $display("FAIL mid_after got bit=%b bal=%0d vld=%b exp %b/%0d/1", cur_bit, cur_bal, cur_vld, e.b, e.bal);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        int   m;
        dsel = 2;
        do_reset();
        m = 0;
        for (int i = 0; i < 30; i++) begin
            if (i < 10) begin
                m = (m < 7) ? m + 1 : 7;
                drive(16'h1234, 1'b1, 1'b1, m);
            end else begin
                m = (m > -8) ? m - 1 : -8;
                drive(16'hC000, 1'b1, 1'b0, m);
            end
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                total++; bad++; $display("FAIL sat_sb_empty[%0d] got=0 exp>=1", i);
            end else begin
                e = sb.pop_front();
                total++;
                if (cur_bit !== e.b || cur_bal !== e.bal) begin
                    bad++; $display("FAIL sat_bal[%0d] got bit=%b bal=%0d exp %b/%0d", i, cur_bit, cur_bal, e.b, e.bal);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        chaotic_value = '0;
        test_reset();
        test_sign_and_bounds();
        test_hysteresis();
        test_idle();
        test_reset_midstream();
        test_saturation();
        @(negedge clk);
        in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/opamp_comparator.md
Name: opamp_comparator

Overview:
- Clocked comparator stage of the chaotic LFSR datapath.
- Converts a signed 16-bit chaotic map sample into a single chaos bit, using a threshold with an optional hysteresis band (a Schmitt-style "op-amp").
- Feeds the LFSR mixing stage.
- Also keeps a running ones/zeros balance count for bias monitoring.

Parameters:
- WIDTH, 16: bit width of the signed chaotic sample.
- THRESHOLD, 0: signed comparison threshold, WIDTH bits.
- HYST, 0: unsigned hysteresis half-width, WIDTH-1 bits. HYST=0 gives a plain comparator.
- BAL_WIDTH, 16: width of the signed balance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  chaotic_value is valid this cycle.
- chaotic_value  input  WIDTH  signed two's-complement chaotic sample.
- chaos_bit  output  1  registered comparator decision.
- bit_valid  output  1  chaos_bit updated this cycle (one-cycle pulse per accepted sample).
- balance  output  BAL_WIDTH  signed running count, (#ones − #zeros), saturating.

Behaviour:
- Reset, asynchronous on rst high:
  - chaos_bit=0, bit_valid=0, balance=0.
  - These values hold while rst is high.
  - The first sample is accepted on the first rising edge after rst deasserts.
- Arithmetic:
  - Sign-extend chaotic_value, THRESHOLD and HYST to WIDTH+2 bits.
  - Compute hi = THRESHOLD+HYST and lo = THRESHOLD−HYST at that width. No overflow or wrap is permitted.
- Decision, on each rising edge with in_valid=1:
  - chaotic_value > hi → chaos_bit <= 1.
  - chaotic_value <= lo → chaos_bit <= 0.
  - Otherwise (inside the band) → chaos_bit holds its previous value.
  - With HYST=0 the rule reduces to: chaos_bit = (chaotic_value > THRESHOLD). The value equal to THRESHOLD yields 0.
- Comparison is signed:
  - 0x8000 is the most negative value and 0x7FFF the most positive.
  - The MSB alone must not be used as the decision when THRESHOLD≠0.
- Valid handshake:
  - bit_valid <= in_valid each edge.
  - Latency is exactly 1 cycle from sample to chaos_bit/bit_valid.
  - No backpressure; one sample is accepted per cycle.
- Idle (in_valid=0): chaos_bit and balance hold; bit_valid=0.
- Balance counter:
  - On each accepted sample, balance increments if the new chaos_bit is 1 and decrements if it is 0.
  - It saturates at the max positive / min negative BAL_WIDTH value; there is no wrap.
  - It updates in the same edge as chaos_bit.
- Reset asserted mid-stream: all outputs clear immediately. An in-flight sample is discarded.
- No combinational path from input to output: all outputs are flops.

Test Plan:
- Basic sign decision (THRESHOLD=0, HYST=0):
  - Drive 0x4000, 0x2000, 0x8288, 0xE667 with in_valid=1, one per cycle.
  - Required: chaos_bit 1, 1, 0, 0, each one cycle after its sample, with bit_valid=1.
  - Required: balance ends at 0 (1, 2, 1, 0).
- Boundaries (THRESHOLD=0, HYST=0):
  - Drive 0x0000, 0x0001, 0x7FFF, 0x8000, 0xFFFF.
  - Required: chaos_bit 0, 1, 1, 0, 0.
- Hysteresis (THRESHOLD=0x1000, HYST=0x0100):
  - Drive 0x1200, then 0x1000, then 0x0F00, then 0x1050, then 0x1101.
  - Required: chaos_bit 1, 1 (held in band), 0 (<= 0x0F00), 0 (held), 1.
- Valid gating and idle:
  - Drive 0x4000 with in_valid=1, then 0x8288 with in_valid=0 for 3 cycles.
  - Required: chaos_bit stays 1, bit_valid stays 0 during idle, balance stays 1.
- Reset mid-operation:
  - Stream positive samples until balance=5, then assert rst asynchronously between edges.
  - Required: chaos_bit=0, bit_valid=0, balance=0 immediately.
  - Required: after release, the first sample 0x2000 gives chaos_bit=1 and balance=1.
- Saturation (BAL_WIDTH=4):
  - Drive 10 consecutive positive samples.
  - Required: balance stops at +7.
  - Then drive 20 negative samples. Required: balance stops at −8 with no wrap.
